atm_ctrl_param: RTL and testbench

ATM_CTRL_PARAM -- requirements
Module: atm_ctrl_param

---
 rtl/atm_ctrl_param_if.sv | 43 ++++
 rtl/atm_ctrl_param.sv | 177 +++++++++++++++++
 tb/tb_atm_ctrl_param.sv | 385 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/atm_ctrl_param_if.sv
// Card/PIN/transaction bus of the ATM controller, plus a state debug tap.
// The master side (card reader, keypad, host) drives inputs; the slave is the controller.
interface atm_ctrl_param_if #(
  parameter int PIN_DIGITS = 4,
  parameter int MONTO_W    = 32,
  parameter int BAL_W      = 64
);
  logic                    TARJETA_RECIBIDA;
  logic                    TIPO_DE_TARJETA;
  logic [4*PIN_DIGITS-1:0] PIN;
  logic [3:0]              DIGITO;
  logic                    DIGITO_STB;
  logic                    TIPO_TRANS;
  logic [MONTO_W-1:0]      MONTO;
  logic                    MONTO_STB;
  logic [BAL_W-1:0]        BALANCE_INICIAL;
  logic [BAL_W-1:0]        BALANCE;
  logic                    BALANCE_ACTUALIZADO;
  logic                    ENTREGAR_DINERO;
  logic                    FONDOS_INSUFICIENTES;
  logic                    PIN_INCORRECTO;
  logic                    ADVERTENCIA;
  logic                    BLOQUEO;
  // Debug tap: 0 ESPERA_TARJETA, 1 ESPERA_PIN, 2 IDENTIFICADO, 3 BLOQUEADO.
  logic [1:0]              ESTADO;

  // Strobes (DIGITO_STB, MONTO_STB) are single-cycle valids with no ready:
  // the controller samples them on every rising edge, and a strobe that is
  // not meaningful in the current state is dropped.
  modport master (
    output TARJETA_RECIBIDA, TIPO_DE_TARJETA, PIN, DIGITO, DIGITO_STB,
           TIPO_TRANS, MONTO, MONTO_STB, BALANCE_INICIAL,
    input  BALANCE, BALANCE_ACTUALIZADO, ENTREGAR_DINERO, FONDOS_INSUFICIENTES,
           PIN_INCORRECTO, ADVERTENCIA, BLOQUEO, ESTADO
  );

  modport slave (
    input  TARJETA_RECIBIDA, TIPO_DE_TARJETA, PIN, DIGITO, DIGITO_STB,
           TIPO_TRANS, MONTO, MONTO_STB, BALANCE_INICIAL,
    output BALANCE, BALANCE_ACTUALIZADO, ENTREGAR_DINERO, FONDOS_INSUFICIENTES,
           PIN_INCORRECTO, ADVERTENCIA, BLOQUEO, ESTADO
  );
endinterface

// File: rtl/atm_ctrl_param.sv
// ATM session controller: card load with foreign fee, PIN entry with lockout,
// one withdrawal or saturating deposit per session. All outputs are registered.
module atm_ctrl_param #(
  parameter int PIN_DIGITS   = 4,
  parameter int MONTO_W      = 32,
  parameter int BAL_W        = 64,
  parameter int MAX_INTENTOS = 3,
  parameter int COMISION     = 2
) (
  input  logic             CLK,
  input  logic             RESET,
  atm_ctrl_param_if.slave  bus
);

  localparam int PW  = 4 * PIN_DIGITS;
  localparam int DCW = $clog2(PIN_DIGITS + 1);
  localparam int ACW = $clog2(MAX_INTENTOS + 1);
  localparam logic [DCW-1:0]   ULT_DIG = DCW'(PIN_DIGITS - 1);
  localparam logic [ACW-1:0]   AVISO   = ACW'(MAX_INTENTOS - 1);
  localparam logic [ACW-1:0]   LIMITE  = ACW'(MAX_INTENTOS);
  localparam logic [BAL_W-1:0] COM     = BAL_W'(COMISION);

  typedef enum logic [1:0] {
    ESPERA_TARJETA = 2'd0,
    ESPERA_PIN     = 2'd1,
    IDENTIFICADO   = 2'd2,
    BLOQUEADO      = 2'd3
  } estado_t;

  estado_t          state_q, state_d;
  logic [BAL_W-1:0] bal_q, bal_d;
  logic [PW-1:0]    entry_q, entry_d;
  logic [DCW-1:0]   dig_q, dig_d;
  logic [ACW-1:0]   att_q, att_d;
  logic             adv_q, adv_d;
  logic             blq_q, blq_d;
  logic             act_q, act_d;
  logic             ent_q, ent_d;
  logic             fon_q, fon_d;
  logic             pin_q, pin_d;

  logic [MONTO_W-1:0] monto;
  logic [BAL_W-1:0]   monto_ext;
  logic [BAL_W:0]     suma;
  logic [PW-1:0]      entry_next;
  logic [ACW-1:0]     att_inc;

  assign monto = bus.MONTO;

  always_comb begin
    state_d    = state_q;
    bal_d      = bal_q;
    entry_d    = entry_q;
    dig_d      = dig_q;
    att_d      = att_q;
    adv_d      = adv_q;
    blq_d      = blq_q;
    act_d      = 1'b0;
    ent_d      = 1'b0;
    fon_d      = 1'b0;
    pin_d      = 1'b0;
    monto_ext  = BAL_W'(monto);
    suma       = {1'b0, bal_q} + {1'b0, monto_ext};
    // The digit just strobed enters at the LS nibble; the oldest falls off.
    entry_next = PW'({entry_q, bus.DIGITO});
    att_inc    = att_q + 1'b1;

    case (state_q)
      ESPERA_TARJETA: begin
        if (bus.TARJETA_RECIBIDA) begin
          if (bus.TIPO_DE_TARJETA && (bus.BALANCE_INICIAL < COM)) begin
            fon_d = 1'b1;
          end else begin
            bal_d   = bus.TIPO_DE_TARJETA ? (bus.BALANCE_INICIAL - COM)
                                          : bus.BALANCE_INICIAL;
            act_d   = bus.TIPO_DE_TARJETA;
            dig_d   = '0;
            att_d   = '0;
            entry_d = '0;
            adv_d   = 1'b0;
            state_d = ESPERA_PIN;
          end
        end
      end

      ESPERA_PIN: begin
        if (!bus.TARJETA_RECIBIDA) begin
          state_d = ESPERA_TARJETA;
        end else if (bus.DIGITO_STB) begin
          entry_d = entry_next;
          if (dig_q == ULT_DIG) begin
            dig_d = '0;
            if (entry_next == bus.PIN) begin
              state_d = IDENTIFICADO;
              att_d   = '0;
            end else begin
              pin_d = 1'b1;
              att_d = att_inc;
              if (att_inc == LIMITE) begin
                state_d = BLOQUEADO;
                blq_d   = 1'b1;
              end else if (att_inc == AVISO) begin
                adv_d = 1'b1;
              end
            end
          end else begin
            dig_d = dig_q + 1'b1;
          end
        end
      end

      IDENTIFICADO: begin
        if (!bus.TARJETA_RECIBIDA) begin
          state_d = ESPERA_TARJETA;
        end else if (bus.MONTO_STB) begin
          state_d = ESPERA_TARJETA;
          adv_d   = 1'b0;
          if (bus.TIPO_TRANS) begin
            if (monto_ext <= bal_q) begin
              bal_d = bal_q - monto_ext;
              act_d = 1'b1;
              ent_d = 1'b1;
            end else begin
              fon_d = 1'b1;
            end
          end else begin
            bal_d = suma[BAL_W] ? {BAL_W{1'b1}} : suma[BAL_W-1:0];
            act_d = 1'b1;
          end
        end
      end

      BLOQUEADO: begin
      end

      default: state_d = ESPERA_TARJETA;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= ESPERA_TARJETA;
      bal_q   <= '0;
      entry_q <= '0;
      dig_q   <= '0;
      att_q   <= '0;
      adv_q   <= 1'b0;
      blq_q   <= 1'b0;
      act_q   <= 1'b0;
      ent_q   <= 1'b0;
      fon_q   <= 1'b0;
      pin_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bal_q   <= bal_d;
      entry_q <= entry_d;
      dig_q   <= dig_d;
      att_q   <= att_d;
      adv_q   <= adv_d;
      blq_q   <= blq_d;
      act_q   <= act_d;
      ent_q   <= ent_d;
      fon_q   <= fon_d;
      pin_q   <= pin_d;
    end
  end

  assign bus.BALANCE              = bal_q;
  assign bus.BALANCE_ACTUALIZADO  = act_q;
  assign bus.ENTREGAR_DINERO      = ent_q;
  assign bus.FONDOS_INSUFICIENTES = fon_q;
  assign bus.PIN_INCORRECTO       = pin_q;
  assign bus.ADVERTENCIA          = adv_q;
  assign bus.BLOQUEO              = blq_q;
  assign bus.ESTADO               = state_q;

endmodule

// File: tb/tb_atm_ctrl_param.sv
// Scenario bench for atm_ctrl_param: each task drives one feature and checks
// a full output snapshot against values derived from the session rules.
module tb_atm_ctrl_param;

  localparam logic [1:0] ST_WAIT = 2'd0;
  localparam logic [1:0] ST_PIN  = 2'd1;
  localparam logic [1:0] ST_ID   = 2'd2;
  localparam logic [1:0] ST_BLK  = 2'd3;

  // Event pulse order: BALANCE_ACTUALIZADO, ENTREGAR_DINERO, FONDOS, PIN_INCORRECTO.
  localparam logic [3:0] EV_NONE = 4'b0000;
  localparam logic [3:0] EV_ACT  = 4'b1000;
  localparam logic [3:0] EV_ENT  = 4'b0100;
  localparam logic [3:0] EV_FON  = 4'b0010;
  localparam logic [3:0] EV_PIN  = 4'b0001;
  localparam logic [63:0] BAL_MAX = 64'hFFFF_FFFF_FFFF_FFFF;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  atm_ctrl_param_if #(.PIN_DIGITS(4), .MONTO_W(32), .BAL_W(64)) bus ();

  atm_ctrl_param #(
    .PIN_DIGITS(4), .MONTO_W(32), .BAL_W(64), .MAX_INTENTOS(3), .COMISION(2)
  ) dut (
    .CLK   (clk),
    .RESET (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [71:0] snap();
    return {bus.ESTADO, bus.ADVERTENCIA, bus.BLOQUEO, bus.BALANCE_ACTUALIZADO,
            bus.ENTREGAR_DINERO, bus.FONDOS_INSUFICIENTES, bus.PIN_INCORRECTO,
            bus.BALANCE};
  endfunction

  function automatic logic [71:0] exp_snap(logic [1:0] st, logic adv, logic blq,
                                           logic [3:0] ev, logic [63:0] bal);
    return {st, adv, blq, ev, bal};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.TARJETA_RECIBIDA = 1'b0;
    bus.TIPO_DE_TARJETA  = 1'b0;
    bus.PIN              = '0;
    bus.DIGITO           = '0;
    bus.DIGITO_STB       = 1'b0;
    bus.TIPO_TRANS       = 1'b0;
    bus.MONTO            = '0;
    bus.MONTO_STB        = 1'b0;
    bus.BALANCE_INICIAL  = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic insert(input logic foreign, input logic [63:0] bal, input logic [15:0] pin);
    bus.TARJETA_RECIBIDA = 1'b1;
    bus.TIPO_DE_TARJETA  = foreign;
    bus.BALANCE_INICIAL  = bal;
    bus.PIN              = pin;
    tick();
  endtask

  task automatic digit(input logic [3:0] d);
    bus.DIGITO     = d;
    bus.DIGITO_STB = 1'b1;
    tick();
    bus.DIGITO_STB = 1'b0;
  endtask

  task automatic enter(input logic [15:0] code, input int n);
    for (int i = 0; i < n; i++) digit(code[15-4*i -: 4]);
  endtask

  // One transaction; the card is pulled right after so the session ends idle.
  task automatic trans(input logic withdraw, input logic [31:0] amt);
    bus.TIPO_TRANS = withdraw;
    bus.MONTO      = amt;
    bus.MONTO_STB  = 1'b1;
    tick();
    bus.MONTO_STB        = 1'b0;
    bus.TARJETA_RECIBIDA = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [71:0] e;
    do_reset();
    e = exp_snap(ST_WAIT, 0, 0, EV_NONE, 64'd0);
    checks++;
    if (snap() !== e) begin failures++; $display("FAIL reset_state: got %h expected %h", snap(), e); end
  endtask

  task automatic test_basic_withdraw();
    logic [71:0] e;
    do_reset();
    insert(0, 64'd1000, 16'h1234);
    e = exp_snap(ST_PIN, 0, 0, EV_NONE, 64'd1000);
    checks++;
    if (snap() !== e) begin failures++; $display("FAIL basic_insert: got %h expected %h", snap(), e); end
    enter(16'h1234, 4);
    e = exp_snap(ST_ID, 0, 0, EV_NONE, 64'd1000);
    checks++;
    if (snap() !== e) begin failures++; $display("FAIL basic_pin_ok: got %h expected %h", snap(), e); end
    trans(1, 32'd300);
    e = exp_snap(ST_WAIT, 0, 0, EV_ACT | EV_ENT, 64'd700);
    checks++;
    if (snap() !== e) begin failures++; $display("FAIL basic_withdraw: got %h expected %h", snap(), e); end
    tick();
    e = exp_snap(ST_WAIT, 0, 0, EV_NONE, 64'd700);
    checks++;
    if (snap() !== e) begin failures++; $display("FAIL basic_pulse_end: got %h expected %h", snap(), e); end
  endtask

  task automatic test_foreign();
    logic [71:0] e;
    logic [63:0] b, held;
    do_reset();
    insert(1, 64'd1, 16'h5555);
    e = exp_snap(ST_WAIT, 0, 0, EV_FON, 64'd0);
    checks++;
    if (snap() !== e) begin failures++; $display("FAIL foreign_low: got %h expected %h", snap(), e); end
    bus.TARJETA_RECIBIDA = 1'b0;
    tick();
    e = exp_snap(ST_WAIT, 0, 0, EV_NONE, 64'd0);
    checks++;
    if (snap() !== e) begin failures++; $display("FAIL foreign_low_single: got %h expected %h", snap(), e); end
    insert(1, 64'd10, 16'h5555);
    e = exp_snap(ST_PIN, 0, 0, EV_ACT, 64'd8);
    checks++;
    if (snap() !== e) begin failures++; $display("FAIL foreign_fee: got %h expected %h", snap(), e); end
    bus.TARJETA_RECIBIDA = 1'b0;
    tick();
    held = 64'd8;
    for (int k = 0; k < 6; k++) begin
      b = 64'($urandom_range(0, 4));
      insert(1, b, 16'h5555);
      if (b < 2) e = exp_snap(ST_WAIT, 0, 0, EV_FON, held);
      else begin held = b - 64'd2; e = exp_snap(ST_PIN, 0, 0, EV_ACT, held); end
      checks++;
      if (snap() !== e) begin failures++; $display("FAIL foreign_rand b=%0d: got %h expected %h", b, snap(), e); end
      bus.TARJETA_RECIBIDA = 1'b0;
      tick();
    end
  endtask

  task automatic test_lockout();
    logic [71:0] e;
    logic [15:0] pin, bad;
    do_reset();
    pin = 16'($urandom);
    insert(0, 64'd500, pin);
    for (int k = 1; k <= 3; k++) begin
      do bad = 16'($urandom); while (bad == pin);
      enter(bad, 4);
      e = exp_snap((k == 3) ? ST_BLK : ST_PIN, k >= 2, k == 3, EV_PIN, 64'd500);
      checks++;
      if (snap() !== e) begin failures++; $display("FAIL lock_try%0d: got %h expected %h", k, snap(), e); end
      tick();
      e = exp_snap((k == 3) ? ST_BLK : ST_PIN, k >= 2, k == 3, EV_NONE, 64'd500);
      checks++;
      if (snap() !== e) begin failures++; $display("FAIL lock_try%0d_after: got %h expected %h", k, snap(), e); end
    end
    enter(pin, 4);
    e = exp_snap(ST_BLK, 1, 1, EV_NONE, 64'd500);
    checks++;
    if (snap() !== e) begin failures++; $display("FAIL lock_right_pin: got %h expected %h", snap(), e); end
    bus.TARJETA_RECIBIDA = 1'b0;
    tick();
    insert(0, 64'd9999, pin);
    e = exp_snap(ST_BLK, 1, 1, EV_NONE, 64'd500);
    checks++;
    if (snap() !== e) begin failures++; $display("FAIL lock_reinsert: got %h expected %h", snap(), e); end
    do_reset();
    e = exp_snap(ST_WAIT, 0, 0, EV_NONE, 64'd0);
    checks++;
    if (snap() !== e) begin failures++; $display("FAIL lock_reset_exit: got %h expected %h", snap(), e); end
  endtask

  task automatic test_exact_balance();
    logic [71:0] e;
    do_reset();
    insert(0, 64'd1000, 16'h0909);
    enter(16'h0909, 4);
    trans(1, 32'd1000);
    e = exp_snap(ST_WAIT, 0, 0, EV_ACT | EV_ENT, 64'd0);
    checks++;
    if (snap() !== e) begin failures++; $display("FAIL exact_withdraw: got %h expected %h", snap(), e); end
    tick();
    insert(0, 64'd1000, 16'h0909);
    enter(16'h0909, 4);
    trans(1, 32'd1001);
    e = exp_snap(ST_WAIT, 0, 0, EV_FON, 64'd1000);
    checks++;
    if (snap() !== e) begin failures++; $display("FAIL over_withdraw: got %h expected %h", snap(), e); end
    tick();
  endtask

  task automatic test_abort();
    logic [71:0] e;
    logic [15:0] pin;
    do_reset();
    pin = 16'($urandom);
    insert(0, 64'd200, pin);
    enter(pin, 2);
    bus.TARJETA_RECIBIDA = 1'b0;
    tick();
    e = exp_snap(ST_WAIT, 0, 0, EV_NONE, 64'd200);
    checks++;
    if (snap() !== e) begin failures++; $display("FAIL abort_pin: got %h expected %h", snap(), e); end
    insert(0, 64'd200, pin);
    enter(pin, 3);
    e = exp_snap(ST_PIN, 0, 0, EV_NONE, 64'd200);
    checks++;
    if (snap() !== e) begin failures++; $display("FAIL abort_three_digits: got %h expected %h", snap(), e); end
    digit(pin[3:0]);
    e = exp_snap(ST_ID, 0, 0, EV_NONE, 64'd200);
    checks++;
    if (snap() !== e) begin failures++; $display("FAIL abort_fourth_digit: got %h expected %h", snap(), e); end
    bus.TARJETA_RECIBIDA = 1'b0;
    bus.TIPO_TRANS = 1'b0;
    bus.MONTO      = 32'd50;
    bus.MONTO_STB  = 1'b1;
    tick();
    bus.MONTO_STB  = 1'b0;
    e = exp_snap(ST_WAIT, 0, 0, EV_NONE, 64'd200);
    checks++;
    if (snap() !== e) begin failures++; $display("FAIL abort_priority: got %h expected %h", snap(), e); end
  endtask

  task automatic test_ignore_strobes();
    logic [71:0] e;
    logic [15:0] pin;
    do_reset();
    pin = 16'($urandom);
    insert(0, 64'd300, pin);
    bus.TIPO_TRANS = 1'b1;
    bus.MONTO      = 32'd10;
    bus.MONTO_STB  = 1'b1;
    digit(pin[15:12]);
    bus.MONTO_STB  = 1'b0;
    e = exp_snap(ST_PIN, 0, 0, EV_NONE, 64'd300);
    checks++;
    if (snap() !== e) begin failures++; $display("FAIL ignore_monto_in_pin: got %h expected %h", snap(), e); end
    digit(pin[11:8]); digit(pin[7:4]); digit(pin[3:0]);
    e = exp_snap(ST_ID, 0, 0, EV_NONE, 64'd300);
    checks++;
    if (snap() !== e) begin failures++; $display("FAIL ignore_digit_counted: got %h expected %h", snap(), e); end
    digit(4'h7);
    e = exp_snap(ST_ID, 0, 0, EV_NONE, 64'd300);
    checks++;
    if (snap() !== e) begin failures++; $display("FAIL ignore_digit_in_id: got %h expected %h", snap(), e); end
    bus.DIGITO_STB = 1'b1;
    trans(0, 32'd5);
    bus.DIGITO_STB = 1'b0;
    e = exp_snap(ST_WAIT, 0, 0, EV_ACT, 64'd305);
    checks++;
    if (snap() !== e) begin failures++; $display("FAIL ignore_dual_strobe: got %h expected %h", snap(), e); end
    tick();
  endtask

  task automatic test_random_sessions();
    logic [71:0] e;
    logic [63:0] held, b, nb;
    logic [31:0] amt;
    logic [15:0] pin;
    logic        foreign, wd;
    do_reset();
    held = 64'd0;
    for (int k = 0; k < 20; k++) begin
      foreign = 1'($urandom);
      b       = 64'($urandom_range(0, 3000));
      pin     = 16'($urandom);
      insert(foreign, b, pin);
      if (foreign && b < 2) begin
        e = exp_snap(ST_WAIT, 0, 0, EV_FON, held);
        checks++;
        if (snap() !== e) begin failures++; $display("FAIL rand%0d_insert: got %h expected %h", k, snap(), e); end
        bus.TARJETA_RECIBIDA = 1'b0;
        tick();
        continue;
      end
      held = foreign ? b - 64'd2 : b;
      enter(pin, 4);
      wd  = 1'($urandom);
      amt = 32'($urandom_range(0, 3500));
      trans(wd, amt);
      if (!wd) begin
        held = held + 64'(amt);
        e = exp_snap(ST_WAIT, 0, 0, EV_ACT, held);
      end else if (64'(amt) <= held) begin
        nb   = held - 64'(amt);
        held = nb;
        e = exp_snap(ST_WAIT, 0, 0, EV_ACT | EV_ENT, held);
      end else begin
        e = exp_snap(ST_WAIT, 0, 0, EV_FON, held);
      end
      checks++;
      if (snap() !== e) begin failures++; $display("FAIL rand%0d_trans: got %h expected %h", k, snap(), e); end
      tick();
    end
  endtask

  task automatic test_saturation_and_reset();
    logic [71:0] e;
    logic [64:0] sum;
    logic [63:0] b, x;
    logic [31:0] amt;
    do_reset();
    insert(0, BAL_MAX, 16'h4321);
    enter(16'h4321, 4);
    amt = 32'($urandom_range(1, 1000));
    trans(0, amt);
    e = exp_snap(ST_WAIT, 0, 0, EV_ACT, BAL_MAX);
    checks++;
    if (snap() !== e) begin failures++; $display("FAIL sat_at_max: got %h expected %h", snap(), e); end
    tick();
    for (int k = 0; k < 4; k++) begin
      b   = BAL_MAX - 64'd37;
      amt = 32'($urandom_range(0, 74));
      insert(0, b, 16'h4321);
      enter(16'h4321, 4);
      trans(0, amt);
      sum = {1'b0, b} + {33'd0, amt};
      x   = sum[64] ? BAL_MAX : sum[63:0];
      e = exp_snap(ST_WAIT, 0, 0, EV_ACT, x);
      checks++;
      if (snap() !== e) begin failures++; $display("FAIL sat_near amt=%0d: got %h expected %h", amt, snap(), e); end
      tick();
    end
    insert(0, 64'd5000, 16'h4321);
    enter(16'h4321, 4);
    bus.TIPO_TRANS = 1'b0;
    bus.MONTO      = 32'd77;
    bus.MONTO_STB  = 1'b1;
    @(posedge clk);
    #2;
    e = exp_snap(ST_WAIT, 0, 0, EV_ACT, 64'd5077);
    checks++;
    if (snap() !== e) begin failures++; $display("FAIL midrst_deposit: got %h expected %h", snap(), e); end
    rst_n = 1'b0;
    #1;
    e = exp_snap(ST_WAIT, 0, 0, EV_NONE, 64'd0);
    checks++;
    if (snap() !== e) begin failures++; $display("FAIL midrst_async: got %h expected %h", snap(), e); end
    clear_inputs();
    #2;
    rst_n = 1'b1;
    tick();
    checks++;
    if (snap() !== e) begin failures++; $display("FAIL midrst_after: got %h expected %h", snap(), e); end
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_basic_withdraw();
    test_foreign();
    test_lockout();
    test_exact_balance();
    test_abort();
    test_ignore_strobes();
    test_random_sessions();
    test_saturation_and_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
